// File: rtl/if_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch stage: instruction width,
// default reset PC and bubble word, FSM state encodings and an alignment helper.
package if_fetch_unit_pkg;

  localparam int          INST_W       = 32;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;  // sll $0,$0,0
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HELD = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits so every fetch address is word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for an instruction word and its address.
// Captures the memory response when the pipeline stalls so the word can be
// replayed after the stall, since the synchronous memory will not repeat it.
module fetch_hold_buf
  import if_fetch_unit_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [INST_W-1:0] d_inst,
  input  logic [31:0]       d_pc,
  output logic [INST_W-1:0] q_inst,
  output logic [31:0]       q_pc,
  output logic              valid
);

  // Valid flag: cleared by reset or an explicit clear, set on load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (!rst_n || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // Payload: only written on load and qualified by valid, so it needs no reset.
  always_ff @(posedge clk) begin
    // NOTE: data registers are deliberately left out of reset; the valid flag
    // alone decides whether their contents mean anything.
    if (load) begin
      q_inst <= d_inst;
      q_pc   <= d_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues requests to the synchronous
// instruction memory and produces the word/address pair for the IF/ID register.
// Honours the shared stall without losing or duplicating words and turns EX
// redirects into a squashed (bubble) cycle followed by the target stream.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_target,
  output logic              imem_en,
  output logic [31:0]       imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic [INST_W-1:0] instruction_next,
  output logic [31:0]       inst_address_next,
  output logic              inst_valid_next,
  output logic              fetch_misalign
);

  fetch_state_e state, state_nxt;
  logic [31:0]  pc, pc_nxt;
  logic [31:0]  req_pc, req_pc_nxt;
  logic         misalign_nxt;

  logic              buf_load;
  logic              buf_clear;
  logic [INST_W-1:0] buf_inst;
  logic [31:0]       buf_pc;
  logic              buf_valid;

  logic [31:0] redirect_aligned;
  assign redirect_aligned = word_align(redirect_target);

  fetch_hold_buf u_hold_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (buf_load),
    .clear  (buf_clear),
    .d_inst (imem_rdata),
    .d_pc   (req_pc),
    .q_inst (buf_inst),
    .q_pc   (buf_pc),
    .valid  (buf_valid)
  );

  // State, PC, in-flight address and misalign pulse registers (synchronous reset).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= S_BOOT;
      pc             <= word_align(RESET_PC);
      req_pc         <= '0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_nxt;
      pc             <= pc_nxt;
      req_pc         <= req_pc_nxt;
      fetch_misalign <= misalign_nxt;
    end
  end

  // Next-PC mux, fetch request and IF/ID-side outputs; redirect overrides the FSM.
  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves a signal unassigned and no latch is inferred.
    state_nxt         = state;
    pc_nxt            = pc;
    req_pc_nxt        = req_pc;
    misalign_nxt      = 1'b0;
    buf_load          = 1'b0;
    buf_clear         = 1'b0;
    imem_en           = 1'b0;
    imem_addr         = word_align(pc);
    instruction_next  = NOP_INST;
    inst_address_next = '0;
    inst_valid_next   = 1'b0;

    if (!rst_n) begin
      // Reset discards everything; outputs stay at the bubble defaults.
    end else if (redirect_valid) begin
      imem_en      = 1'b1;
      imem_addr    = redirect_aligned;
      req_pc_nxt   = redirect_aligned;
      pc_nxt       = redirect_aligned + 32'd4;
      buf_clear    = 1'b1;
      misalign_nxt = (redirect_target[1:0] != 2'b00);
      state_nxt    = S_RUN;
    end else begin
      unique case (state)
        S_BOOT: begin
          imem_en    = 1'b1;
          req_pc_nxt = pc;
          pc_nxt     = pc + 32'd4;
          state_nxt  = S_RUN;
        end
        S_RUN: begin
          instruction_next  = imem_rdata;
          inst_address_next = req_pc;
          inst_valid_next   = 1'b1;
          if (stall) begin
            // Park the response; the memory will not present it again.
            buf_load  = 1'b1;
            state_nxt = S_HELD;
          end else begin
            imem_en    = 1'b1;
            req_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
          end
        end
        S_HELD: begin
          instruction_next  = buf_inst;
          inst_address_next = buf_pc;
          inst_valid_next   = buf_valid;
          if (!stall) begin
            imem_en    = 1'b1;
            req_pc_nxt = pc;
            pc_nxt     = pc + 32'd4;
            buf_clear  = 1'b1;
            state_nxt  = S_RUN;
          end
        end
        default: begin
          state_nxt = S_BOOT;
        end
      endcase
    end
  end

endmodule
